// File: rtl/systolic_array_sequencer.sv
// systolic_array_sequencer
//
// Purpose:
//   Sequences one tile through an N_ROWS x N_COLS output-stationary PE array.
//   For each accepted start it runs: MAC feed/drain pulses, an optional bias
//   strobe, an optional activation strobe, then a row-by-row shift-out. Every
//   bias/activation/shift strobe is followed by SETTLE_CYCLES of waiting so
//   the PE accumulators hold the overwritten value before the next step.
//
// Ports:
//   core_clk, rst         clock, synchronous active-high reset
//   start                 start a tile (accepted only while ready_for_start=1)
//   ready_for_start       high while idle
//   cfg_k_len, cfg_bias_en, cfg_act_en, cfg_act_sel
//                         tile configuration, captured on an accepted start
//   feed_valid            edge feeders present operand k this cycle
//   pulse_systolic        MAC pulse broadcast to every PE
//   bias_valid            one-cycle bias strobe
//   activation_valid      one-cycle activation strobe
//   activation            captured activation select
//   shift_valid           one-cycle shift strobe
//   out_ready             downstream can accept a row (sampled in SHIFT only)
//   row_valid             bottom-row accumulator valid (same as shift_valid)
//   row_idx               index of the row being emitted
//   done                  one-cycle pulse after the last shift has settled
//
// Optional feature (macro SEQ_PERF_COUNTERS_EN):
//   perf_busy_cycles      saturating count of non-idle cycles
//   perf_stall_cycles     saturating count of SHIFT cycles with out_ready=0
//   Both clear on reset and on an accepted start.

module systolic_array_sequencer #(
  parameter int N_ROWS        = 8,
  parameter int N_COLS        = 8,
  parameter int K_WIDTH       = 16,
  parameter int SETTLE_CYCLES = 3,
  parameter int ACT_WIDTH     = 2,
  localparam int ROW_W        = (N_ROWS > 1) ? $clog2(N_ROWS) : 1
) (
  input  logic                 core_clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready_for_start,
  input  logic [K_WIDTH-1:0]   cfg_k_len,
  input  logic                 cfg_bias_en,
  input  logic                 cfg_act_en,
  input  logic [ACT_WIDTH-1:0] cfg_act_sel,
  output logic                 feed_valid,
  output logic                 pulse_systolic,
  output logic                 bias_valid,
  output logic                 activation_valid,
  output logic [ACT_WIDTH-1:0] activation,
  output logic                 shift_valid,
  input  logic                 out_ready,
  output logic                 row_valid,
  output logic [ROW_W-1:0]     row_idx,
  output logic                 done
`ifdef SEQ_PERF_COUNTERS_EN
  ,output logic [31:0]         perf_busy_cycles,
  output logic [31:0]          perf_stall_cycles
`endif
);

  localparam int CNT_W  = K_WIDTH + 1;
  localparam int WAIT_W = $clog2(SETTLE_CYCLES + 1);

  // Last FEED count is k_len + N_ROWS + N_COLS - 3 (count starts at 0).
  localparam logic [CNT_W-1:0]  EDGE_EXTRA = CNT_W'(N_ROWS + N_COLS - 3);
  localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(N_ROWS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_BIAS,
    S_ACT,
    S_SHIFT,
    S_WAIT,
    S_DONE
  } state_t;

  state_t              state, state_n;
  state_t              ret_state, ret_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [ROW_W-1:0]    row_cnt, row_n;
  logic [K_WIDTH-1:0]  k_len_q;
  logic                bias_en_q;
  logic                act_en_q;
  logic                accept;
  logic [CNT_W-1:0]    feed_last;

  assign accept    = (state == S_IDLE) && start;
  assign feed_last = {1'b0, k_len_q} + EDGE_EXTRA;
  assign row_valid = shift_valid;

  // Next-state logic. WAIT is shared by all settle periods; ret_state tells
  // it where to go afterwards. The row counter wraps after the last row so
  // that row_idx reads 0 again once the tile is finished.
  always_comb begin
    state_n = state;
    ret_n   = ret_state;
    cnt_n   = cnt;
    wait_n  = wait_cnt;
    row_n   = row_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          cnt_n = '0;
          row_n = '0;
          if (cfg_k_len != '0)   state_n = S_FEED;
          else if (cfg_bias_en)  state_n = S_BIAS;
          else if (cfg_act_en)   state_n = S_ACT;
          else                   state_n = S_SHIFT;
        end
      end
      S_FEED: begin
        if (cnt == feed_last) begin
          if (bias_en_q)      state_n = S_BIAS;
          else if (act_en_q)  state_n = S_ACT;
          else                state_n = S_SHIFT;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_BIAS: begin
        state_n = S_WAIT;
        wait_n  = WAIT_INIT;
        ret_n   = act_en_q ? S_ACT : S_SHIFT;
      end
      S_ACT: begin
        state_n = S_WAIT;
        wait_n  = WAIT_INIT;
        ret_n   = S_SHIFT;
      end
      S_SHIFT: begin
        if (out_ready) begin
          state_n = S_WAIT;
          wait_n  = WAIT_INIT;
          if (row_cnt == LAST_ROW) begin
            row_n = '0;
            ret_n = S_DONE;
          end else begin
            row_n = row_cnt + ROW_W'(1);
            ret_n = S_SHIFT;
          end
        end
      end
      S_WAIT: begin
        if (wait_cnt == '0) state_n = ret_state;
        else                wait_n  = wait_cnt - WAIT_W'(1);
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, counters, captured configuration and registered outputs. Strobes
  // are decoded from the current state, so each one lags its state by a
  // cycle; ready_for_start tracks the idle state itself so start is only
  // accepted when it reads high.
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state            <= S_IDLE;
      ret_state        <= S_IDLE;
      cnt              <= '0;
      wait_cnt         <= '0;
      row_cnt          <= '0;
      k_len_q          <= '0;
      bias_en_q        <= 1'b0;
      act_en_q         <= 1'b0;
      activation       <= '0;
      ready_for_start  <= 1'b1;
      feed_valid       <= 1'b0;
      pulse_systolic   <= 1'b0;
      bias_valid       <= 1'b0;
      activation_valid <= 1'b0;
      shift_valid      <= 1'b0;
      row_idx          <= '0;
      done             <= 1'b0;
    end else begin
      state     <= state_n;
      ret_state <= ret_n;
      cnt       <= cnt_n;
      wait_cnt  <= wait_n;
      row_cnt   <= row_n;
      if (accept) begin
        k_len_q    <= cfg_k_len;
        bias_en_q  <= cfg_bias_en;
        act_en_q   <= cfg_act_en;
        activation <= cfg_act_sel;
      end
      ready_for_start  <= (state_n == S_IDLE);
      pulse_systolic   <= (state == S_FEED);
      feed_valid       <= (state == S_FEED) && (cnt < {1'b0, k_len_q});
      bias_valid       <= (state == S_BIAS);
      activation_valid <= (state == S_ACT);
      shift_valid      <= (state == S_SHIFT) && out_ready;
      row_idx          <= row_cnt;
      done             <= (state == S_DONE);
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  // Saturating activity counters, restarted for every accepted tile.
  always_ff @(posedge core_clk) begin
    if (rst || accept) begin
      perf_busy_cycles  <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if ((state != S_IDLE) && (perf_busy_cycles != '1))
        perf_busy_cycles <= perf_busy_cycles + 32'd1;
      if ((state == S_SHIFT) && !out_ready && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule
